// File: rtl/mux_pkg.sv
// Shared types and constants for the three-source mux select arbiter.
// Holds FSM state encoding, mux select codes and source indices.
package mux_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    localparam logic [1:0] SEL_A    = 2'b00;
    localparam logic [1:0] SEL_B    = 2'b01;
    localparam logic [1:0] SEL_C    = 2'b10;
    localparam logic [1:0] SEL_NONE = 2'b11;

    localparam int IDX_A = 0;
    localparam int IDX_B = 1;
    localparam int IDX_C = 2;

    localparam logic [2:0] OH_A    = 3'b001;
    localparam logic [2:0] OH_B    = 3'b010;
    localparam logic [2:0] OH_C    = 3'b100;
    localparam logic [2:0] OH_NONE = 3'b000;

    // Mux select code for a one-hot grant; no grant maps to SEL_NONE.
    function automatic logic [1:0] sel_of(input logic [2:0] g);
        logic [1:0] s;
        s = SEL_NONE;
        if (g[IDX_A])
            s = SEL_A;
        else if (g[IDX_B])
            s = SEL_B;
        else if (g[IDX_C])
            s = SEL_C;
        return s;
    endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational three-way round-robin picker.
// Ports: req_i requests, last_i one-hot previous holder, win_o one-hot winner.
module rr_pick3
    import mux_pkg::*;
(
    input  logic [2:0] req_i,
    input  logic [2:0] last_i,
    output logic [2:0] win_o
);

    // Search starts at the slot after last_i and wraps C -> A.
    // A last_i of all zeros behaves like last=C.
    always_comb begin
        win_o = OH_NONE;
        unique case (1'b1)
            last_i[IDX_A]: begin
                if (req_i[IDX_B])      win_o = OH_B;
                else if (req_i[IDX_C]) win_o = OH_C;
                else if (req_i[IDX_A]) win_o = OH_A;
            end
            last_i[IDX_B]: begin
                if (req_i[IDX_C])      win_o = OH_C;
                else if (req_i[IDX_A]) win_o = OH_A;
                else if (req_i[IDX_B]) win_o = OH_B;
            end
            default: begin
                if (req_i[IDX_A])      win_o = OH_A;
                else if (req_i[IDX_B]) win_o = OH_B;
                else if (req_i[IDX_C]) win_o = OH_C;
            end
        endcase
    end

endmodule

// File: rtl/mux_sel_arb.sv
// Round-robin arbiter driving the select lines of a three-source mux.
// Ports: clk, rst (sync, active-high), req[2:0], done -> s1, s0, gnt[2:0],
// gnt_valid, timeout. Define MUX_SEL_ARB_TIMEOUT_EN to cap a holder at
// MAX_HOLD grant cycles; otherwise grants are held indefinitely.
module mux_sel_arb
    import mux_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic       done,
    output logic       s1,
    output logic       s0,
    output logic [2:0] gnt,
    output logic       gnt_valid,
    output logic       timeout
);

    state_e     state_q;
    logic [2:0] gnt_q;
    logic [2:0] last_q;
    logic [1:0] sel_q;
    logic [2:0] pick_d;
    logic       rel_d;

    rr_pick3 u_pick (
        .req_i  (req),
        .last_i (last_q),
        .win_o  (pick_d)
    );

    // Holder lets go on done or on dropping its own request.
    assign rel_d = done | ~|(req & gnt_q);

`ifdef MUX_SEL_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);
    logic [7:0] cnt_q;
    logic       to_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= OH_NONE;
            sel_q   <= SEL_NONE;
            last_q  <= OH_C;
            cnt_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            to_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (|req) begin
                        state_q <= ST_GRANT;
                        gnt_q   <= pick_d;
                        sel_q   <= sel_of(pick_d);
                        cnt_q   <= 8'd1;
                    end
                end
                ST_GRANT: begin
                    if (rel_d || cnt_q == HOLD_MAX) begin
                        state_q <= ST_IDLE;
                        gnt_q   <= OH_NONE;
                        sel_q   <= SEL_NONE;
                        last_q  <= gnt_q;
                        cnt_q   <= '0;
                        // done wins over a simultaneous expiry.
                        to_q    <= ~rel_d;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign timeout = to_q;
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= OH_NONE;
            sel_q   <= SEL_NONE;
            last_q  <= OH_C;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (|req) begin
                        state_q <= ST_GRANT;
                        gnt_q   <= pick_d;
                        sel_q   <= sel_of(pick_d);
                    end
                end
                ST_GRANT: begin
                    if (rel_d) begin
                        state_q <= ST_IDLE;
                        gnt_q   <= OH_NONE;
                        sel_q   <= SEL_NONE;
                        last_q  <= gnt_q;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign timeout = 1'b0;
`endif

    assign gnt       = gnt_q;
    assign gnt_valid = (state_q == ST_GRANT);
    assign s1        = sel_q[1];
    assign s0        = sel_q[0];

endmodule
